// File: rtl/spo2_pkg.sv
// Shared constants, FSM state type and helpers for the SpO2 ratio datapath.
package spo2_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned FRAC_DEF = 8;
    localparam int unsigned QW_DEF   = 12;
    localparam int unsigned NUM_W    = 24;  // (RED_AC*IR_DC) << FRAC
    localparam int unsigned DEN_W    = 16;  // IR_AC*RED_DC

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        DIV,
        DONE
    } state_e;

    // (hi + lo) >> 1 computed in 9 bits so the carry is kept.
    function automatic logic [DATA_W-1:0] mid_point(input logic [DATA_W-1:0] hi,
                                                    input logic [DATA_W-1:0] lo);
        logic [DATA_W:0] sum;
        sum = {1'b0, hi} + {1'b0, lo};
        return sum[DATA_W:1];
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle, MSB first.
// The caller guarantees dividend >> QW < divisor, so the quotient fits in QW bits.
module seq_divider #(
    parameter int unsigned NW = 24,
    parameter int unsigned DW = 16,
    parameter int unsigned QW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [NW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [QW-1:0] quotient
);

    localparam int unsigned CW = $clog2(QW + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(QW - 1);

    logic          busy_q;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] rem_q;
    logic [QW-1:0] low_q;
    logic [QW-1:0] quo_q;
    logic [DW-1:0] dvs_q;

    logic [DW:0]   trial;
    logic [DW:0]   diff;
    logic          ge;
    logic [DW-1:0] rem_n;

    // One restoring step: shift in the next dividend bit and try to subtract.
    always_comb begin
        trial = {rem_q, low_q[QW-1]};
        diff  = trial - {1'b0, dvs_q};
        ge    = (trial >= {1'b0, dvs_q});
        rem_n = ge ? diff[DW-1:0] : trial[DW-1:0];
    end

    // Quotient includes the bit being resolved this cycle; valid while done is high.
    assign quotient = {quo_q[QW-2:0], ge};
    assign done     = busy_q && (cnt_q == LAST_STEP);
    assign busy     = busy_q;

    // Iteration state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            low_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            rem_q  <= DW'(dividend[NW-1:QW]);
            low_q  <= dividend[QW-1:0];
            quo_q  <= '0;
            dvs_q  <= divisor;
        end else if (busy_q) begin
            rem_q <= rem_n;
            low_q <= {low_q[QW-2:0], 1'b0};
            quo_q <= quotient;
            cnt_q <= cnt_q + 1'b1;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/spo2_ratio_calc.sv
// Windowed min/max tracking of IR/RED samples and the SpO2 ratio
// R = (RED_AC*IR_DC)/(IR_AC*RED_DC) in unsigned Q4.FRAC.
module spo2_ratio_calc
    import spo2_pkg::*;
#(
    parameter int unsigned WINDOW = 256,
    parameter int unsigned FRAC   = FRAC_DEF,
    parameter int unsigned QW     = QW_DEF
) (
    input  logic          CLK,
    input  logic          rst_n,
    input  logic          Sample_Valid,
    input  logic [7:0]    IR_ADC_Value,
    input  logic [7:0]    RED_ADC_Value,
    output logic [7:0]    IR_AC,
    output logic [7:0]    IR_DC,
    output logic [7:0]    RED_AC,
    output logic [7:0]    RED_DC,
    output logic [QW-1:0] Ratio,
    output logic          Ratio_Valid,
    output logic          Ratio_Err,
    output logic          Ratio_Sat,
    output logic          Overrun
);

    localparam logic [15:0] LAST_CNT = 16'(WINDOW - 1);
    localparam int unsigned SW       = DEN_W + QW;

    // Window tracking
    logic [15:0] cnt_q;
    logic [7:0]  ir_max_q, ir_min_q, red_max_q, red_min_q;
    logic [7:0]  ir_max_n, ir_min_n, red_max_n, red_min_n;
    logic [7:0]  ir_ac_q, ir_dc_q, red_ac_q, red_dc_q;
    logic        first, last, close, close_q, overrun_q;

    // Ratio datapath
    state_e             state_q, state_d;
    logic [NUM_W-1:0]   num_q, num_calc;
    logic [DEN_W-1:0]   den_q, den_calc;
    logic [QW-1:0]      ratio_q, ratio_d;
    logic               err_q, err_d, sat_q, sat_d;
    logic               div_start, div_busy, div_done;
    logic [QW-1:0]      div_quo;

    // Running max/min including the sample on the inputs; the first sample reloads.
    always_comb begin
        first     = (cnt_q == '0);
        last      = (cnt_q == LAST_CNT);
        close     = Sample_Valid && last;
        ir_max_n  = (first || IR_ADC_Value > ir_max_q) ? IR_ADC_Value : ir_max_q;
        ir_min_n  = (first || IR_ADC_Value < ir_min_q) ? IR_ADC_Value : ir_min_q;
        red_max_n = (first || RED_ADC_Value > red_max_q) ? RED_ADC_Value : red_max_q;
        red_min_n = (first || RED_ADC_Value < red_min_q) ? RED_ADC_Value : red_min_q;
    end

    // Tracker registers and AC/DC snapshot on the window-closing sample.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            ir_max_q  <= '0;
            ir_min_q  <= '0;
            red_max_q <= '0;
            red_min_q <= '0;
            ir_ac_q   <= '0;
            ir_dc_q   <= '0;
            red_ac_q  <= '0;
            red_dc_q  <= '0;
        end else if (Sample_Valid) begin
            ir_max_q  <= ir_max_n;
            ir_min_q  <= ir_min_n;
            red_max_q <= red_max_n;
            red_min_q <= red_min_n;
            cnt_q     <= last ? '0 : cnt_q + 16'd1;
            if (last) begin
                ir_ac_q  <= ir_max_n - ir_min_n;
                ir_dc_q  <= mid_point(ir_max_n, ir_min_n);
                red_ac_q <= red_max_n - red_min_n;
                red_dc_q <= mid_point(red_max_n, red_min_n);
            end
        end
    end

    // A close pending while the FSM is idle starts a ratio; otherwise it is an overrun.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            close_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            close_q <= close && (state_q == IDLE);
            if (close && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign num_calc = NUM_W'({8'd0, red_ac_q} * {8'd0, ir_dc_q}) << FRAC;
    assign den_calc = {8'd0, ir_ac_q} * {8'd0, red_dc_q};

    // Next state and result capture.
    always_comb begin
        state_d   = state_q;
        ratio_d   = ratio_q;
        err_d     = err_q;
        sat_d     = sat_q;
        div_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (close_q) begin
                    state_d = MULT;
                end
            end
            MULT: begin
                if (den_q == '0) begin
                    ratio_d = '0;
                    err_d   = 1'b1;
                    sat_d   = 1'b0;
                    state_d = DONE;
                end else if (SW'(num_q) >= (SW'(den_q) << QW)) begin
                    ratio_d = '1;
                    err_d   = 1'b0;
                    sat_d   = 1'b1;
                    state_d = DONE;
                end else if (!div_busy) begin
                    div_start = 1'b1;
                    state_d   = DIV;
                end
            end
            DIV: begin
                if (div_done) begin
                    ratio_d = div_quo;
                    err_d   = 1'b0;
                    sat_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, operands and held result.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            num_q   <= '0;
            den_q   <= '0;
            ratio_q <= '0;
            err_q   <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ratio_q <= ratio_d;
            err_q   <= err_d;
            sat_q   <= sat_d;
            if (state_q == IDLE && close_q) begin
                num_q <= num_calc;
                den_q <= den_calc;
            end
        end
    end

    seq_divider #(
        .NW (NUM_W),
        .DW (DEN_W),
        .QW (QW)
    ) u_div (
        .clk      (CLK),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (num_q),
        .divisor  (den_q),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo)
    );

    assign IR_AC       = ir_ac_q;
    assign IR_DC       = ir_dc_q;
    assign RED_AC      = red_ac_q;
    assign RED_DC      = red_dc_q;
    assign Ratio       = ratio_q;
    assign Ratio_Err   = err_q;
    assign Ratio_Sat   = sat_q;
    assign Overrun     = overrun_q;
    assign Ratio_Valid = (state_q == DONE);

endmodule

// File: tb/tb_spo2_ratio_calc.sv
// Directed bench for spo2_ratio_calc with a 16-sample window.
module tb_spo2_ratio_calc;

    logic        CLK = 1'b0;
    logic        rst_n = 1'b0;
    logic        Sample_Valid = 1'b0;
    logic [7:0]  IR_ADC_Value = 8'd0;
    logic [7:0]  RED_ADC_Value = 8'd0;
    logic [7:0]  IR_AC, IR_DC, RED_AC, RED_DC;
    logic [11:0] Ratio;
    logic        Ratio_Valid, Ratio_Err, Ratio_Sat, Overrun;

    int checks = 0;
    int errors = 0;

    spo2_ratio_calc #(
        .WINDOW (16),
        .FRAC   (8),
        .QW     (12)
    ) dut (
        .CLK           (CLK),
        .rst_n         (rst_n),
        .Sample_Valid  (Sample_Valid),
        .IR_ADC_Value  (IR_ADC_Value),
        .RED_ADC_Value (RED_ADC_Value),
        .IR_AC         (IR_AC),
        .IR_DC         (IR_DC),
        .RED_AC        (RED_AC),
        .RED_DC        (RED_DC),
        .Ratio         (Ratio),
        .Ratio_Valid   (Ratio_Valid),
        .Ratio_Err     (Ratio_Err),
        .Ratio_Sat     (Ratio_Sat),
        .Overrun       (Overrun)
    );

    always #5 CLK = ~CLK;

    // Drive 16 accepted samples ramping lo..hi; optional junk idle cycles between them.
    // Returns at the falling edge right after the window-closing edge.
    task automatic drive_window(input int ir_lo, input int ir_hi, input int red_lo,
                                input int red_hi, input bit gaps);
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            Sample_Valid  = 1'b1;
            IR_ADC_Value  = 8'(ir_lo + ((ir_hi - ir_lo) * i) / 15);
            RED_ADC_Value = 8'(red_lo + ((red_hi - red_lo) * i) / 15);
            if (gaps && i != 15) begin
                @(negedge CLK);
                Sample_Valid  = 1'b0;
                IR_ADC_Value  = 8'd0;
                RED_ADC_Value = 8'd255;
            end
        end
        @(negedge CLK);
        Sample_Valid = 1'b0;
    endtask

    // Falling edges from the current one until Ratio_Valid is seen (-1 if never).
    task automatic wait_valid(input int limit, output int lat);
        lat = -1;
        for (int n = 0; n < limit; n++) begin
            if (Ratio_Valid) begin
                lat = n;
                break;
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if ({IR_AC, IR_DC, RED_AC, RED_DC} !== 32'd0) begin
            errors++;
            $display("FAIL reset_acdc: got %h expected 0", {IR_AC, IR_DC, RED_AC, RED_DC});
        end
        checks++;
        if ({Ratio, Ratio_Valid, Ratio_Err, Ratio_Sat, Overrun} !== 16'd0) begin
            errors++;
            $display("FAIL reset_ratio: got %h expected 0",
                     {Ratio, Ratio_Valid, Ratio_Err, Ratio_Sat, Overrun});
        end
        rst_n = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_normal();
        int lat;
        drive_window(100, 200, 50, 100, 1'b0);
        checks++;
        if ({IR_AC, IR_DC, RED_AC, RED_DC} !== {8'd100, 8'd150, 8'd50, 8'd75}) begin
            errors++;
            $display("FAIL normal_acdc: got %0d %0d %0d %0d expected 100 150 50 75",
                     IR_AC, IR_DC, RED_AC, RED_DC);
        end
        wait_valid(40, lat);
        checks++;
        if (lat != 14) begin
            errors++;
            $display("FAIL normal_latency: got %0d expected 14", lat);
        end
        checks++;
        if ({Ratio, Ratio_Err, Ratio_Sat} !== {12'h100, 2'b00}) begin
            errors++;
            $display("FAIL normal_ratio: got %h err %b sat %b expected 100 0 0",
                     Ratio, Ratio_Err, Ratio_Sat);
        end
        @(negedge CLK);
        checks++;
        if (Ratio_Valid !== 1'b0 || Ratio !== 12'h100) begin
            errors++;
            $display("FAIL normal_pulse_hold: got valid %b ratio %h expected 0 100",
                     Ratio_Valid, Ratio);
        end
    endtask

    task automatic test_nonint();
        int lat;
        drive_window(100, 150, 100, 200, 1'b1);
        checks++;
        if ({IR_AC, IR_DC, RED_AC, RED_DC} !== {8'd50, 8'd125, 8'd100, 8'd150}) begin
            errors++;
            $display("FAIL nonint_acdc: got %0d %0d %0d %0d expected 50 125 100 150",
                     IR_AC, IR_DC, RED_AC, RED_DC);
        end
        wait_valid(40, lat);
        checks++;
        if (lat != 14 || Ratio !== 12'h1AA || Ratio_Err !== 1'b0 || Ratio_Sat !== 1'b0) begin
            errors++;
            $display("FAIL nonint_ratio: got lat %0d ratio %h err %b sat %b expected 14 1aa 0 0",
                     lat, Ratio, Ratio_Err, Ratio_Sat);
        end
    endtask

    task automatic test_sat();
        int lat;
        drive_window(100, 101, 0, 255, 1'b0);
        checks++;
        if ({IR_AC, IR_DC, RED_AC, RED_DC} !== {8'd1, 8'd100, 8'd255, 8'd127}) begin
            errors++;
            $display("FAIL sat_acdc: got %0d %0d %0d %0d expected 1 100 255 127",
                     IR_AC, IR_DC, RED_AC, RED_DC);
        end
        wait_valid(40, lat);
        checks++;
        if (lat != 2 || Ratio !== 12'hFFF || Ratio_Sat !== 1'b1 || Ratio_Err !== 1'b0) begin
            errors++;
            $display("FAIL sat_ratio: got lat %0d ratio %h sat %b err %b expected 2 fff 1 0",
                     lat, Ratio, Ratio_Sat, Ratio_Err);
        end
    endtask

    task automatic test_zero();
        int lat;
        drive_window(80, 80, 30, 90, 1'b0);
        checks++;
        if ({IR_AC, IR_DC, RED_DC} !== {8'd0, 8'd80, 8'd60}) begin
            errors++;
            $display("FAIL zero_acdc: got %0d %0d %0d expected 0 80 60", IR_AC, IR_DC, RED_DC);
        end
        wait_valid(40, lat);
        checks++;
        if (lat != 2 || Ratio !== 12'h000 || Ratio_Err !== 1'b1 || Ratio_Sat !== 1'b0) begin
            errors++;
            $display("FAIL zero_ratio: got lat %0d ratio %h err %b sat %b expected 2 000 1 0",
                     lat, Ratio, Ratio_Err, Ratio_Sat);
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int p1 = -1;
        int p2 = -1;
        for (int c = 0; c < 60; c++) begin
            @(negedge CLK);
            if (Ratio_Valid) begin
                pulses++;
                if (p1 < 0) p1 = c;
                else if (p2 < 0) p2 = c;
                checks++;
                if (Ratio !== 12'h100) begin
                    errors++;
                    $display("FAIL b2b_ratio: got %h expected 100", Ratio);
                end
            end
            if (c < 32) begin
                Sample_Valid  = 1'b1;
                IR_ADC_Value  = 8'(100 + (100 * (c % 16)) / 15);
                RED_ADC_Value = 8'(50 + (50 * (c % 16)) / 15);
            end else begin
                Sample_Valid = 1'b0;
            end
        end
        checks++;
        if (pulses != 2 || p1 != 30 || p2 - p1 != 16) begin
            errors++;
            $display("FAIL b2b_pulses: got %0d at %0d,%0d expected 2 at 30,46", pulses, p1, p2);
        end
        checks++;
        if (Overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_overrun: got %b expected 0", Overrun);
        end
    endtask

    task automatic test_reset_mid_div();
        int seen = 0;
        int lat;
        drive_window(100, 200, 50, 100, 1'b0);
        repeat (6) @(negedge CLK);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({IR_AC, IR_DC, RED_AC, RED_DC, Ratio, Ratio_Valid, Ratio_Err, Ratio_Sat,
             Overrun} !== 48'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got %h %h %b%b%b%b expected all 0",
                     {IR_AC, IR_DC, RED_AC, RED_DC}, Ratio, Ratio_Valid, Ratio_Err,
                     Ratio_Sat, Overrun);
        end
        repeat (2) @(negedge CLK);
        rst_n = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge CLK);
            if (Ratio_Valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midreset_no_valid: got %0d pulses expected 0", seen);
        end
        drive_window(100, 150, 100, 200, 1'b0);
        checks++;
        if (IR_AC !== 8'd50 || RED_DC !== 8'd150) begin
            errors++;
            $display("FAIL midreset_acdc: got %0d %0d expected 50 150", IR_AC, RED_DC);
        end
        wait_valid(40, lat);
        checks++;
        if (lat != 14 || Ratio !== 12'h1AA || Ratio_Err !== 1'b0) begin
            errors++;
            $display("FAIL midreset_ratio: got lat %0d ratio %h err %b expected 14 1aa 0",
                     lat, Ratio, Ratio_Err);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_nonint();
        test_sat();
        test_zero();
        test_back_to_back();
        test_reset_mid_div();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spo2_ratio_calc.md
Name: spo2_ratio_calc

Overview:
- Downstream consumer of the LED/PGA controller's per-channel sample outputs (IR_ADC_Value, RED_ADC_Value).
- Over a fixed window of sample pairs it tracks min/max per channel and derives AC = max-min and DC = (max+min)>>1.
- It then computes the SpO2 ratio R = (RED_AC*IR_DC)/(IR_AC*RED_DC) as unsigned fixed point with a multi-cycle sequential divider.
- The output feeds the SpO2 lookup/display stage.

Parameters:
- WINDOW, 256, sample pairs per measurement window; legal range 16..65535.
- FRAC, 8, fractional bits of Ratio.
- QW, 12, Ratio width (4 integer + FRAC fractional bits).

Ports:
- CLK  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- Sample_Valid  in  1  one-cycle strobe; IR_ADC_Value/RED_ADC_Value hold a new pair.
- IR_ADC_Value  in  8  IR channel sample.
- RED_ADC_Value  in  8  RED channel sample.
- IR_AC  out  8  IR max-min of the last closed window.
- IR_DC  out  8  IR (max+min)>>1 of the last closed window.
- RED_AC  out  8  RED max-min of the last closed window.
- RED_DC  out  8  RED (max+min)>>1 of the last closed window.
- Ratio  out  QW  R in unsigned Q4.FRAC.
- Ratio_Valid  out  1  one-cycle pulse; Ratio and flags are updated.
- Ratio_Err  out  1  divide-by-zero for the last result.
- Ratio_Sat  out  1  result clipped to all-ones.
- Overrun  out  1  sticky; a window closed while the divider was busy.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, trackers cleared, window count 0, FSM IDLE. Reset mid-division aborts the division; no Ratio_Valid is generated.
- Tracking:
  - The first accepted sample of a window loads both max and min of each channel.
  - Each later accepted sample updates max/min with unsigned compares.
  - Samples are accepted only when Sample_Valid=1.
- Window close: on the edge accepting sample number WINDOW (count==WINDOW-1):
  - max/min including that sample are snapshotted.
  - IR_AC, IR_DC, RED_AC and RED_DC update on that same edge (E).
  - The count returns to 0 and the next sample starts a fresh window.
  - Tracking never stalls.
- FSM IDLE -> MULT:
  - Trigger: window close while IDLE.
  - At E+1: num = (RED_AC*IR_DC)<<FRAC (24 bit); den = IR_AC*RED_DC (16 bit).
- MULT -> DONE (zero denominator):
  - If den==0 (IR_AC==0 or RED_DC==0): Ratio=0, Ratio_Err=1, Ratio_Sat=0.
- MULT -> DONE (saturation):
  - Else if num >= den<<QW: Ratio=all ones (0xFFF), Ratio_Sat=1, Ratio_Err=0.
- MULT -> DIV (normal case):
  - Otherwise the FSM enters DIV.
  - The restoring divider produces one quotient bit per cycle, MSB first, for QW cycles.
  - The quotient is truncated, not rounded.
- DIV -> DONE: after QW cycles, Ratio = quotient, Err=Sat=0.
- DONE -> IDLE: Ratio_Valid=1 for exactly this cycle.
- Latency from window close edge E to Ratio_Valid high:
  - Normal case: E+QW+2.
  - Err/Sat case: E+2.
- Ratio and the flags hold until the next DONE.
- Overrun:
  - A window close while the FSM is not IDLE still updates the AC/DC outputs.
  - No new division starts for it; Overrun is set and stays set until reset.
  - With WINDOW >= QW+4 this cannot occur at the Sample_Valid rates the controller produces.
- A Sample_Valid coinciding with DONE or any FSM state is always accepted. Tracking and the FSM are independent.
- Arithmetic: all unsigned. DC uses a 9-bit sum, then >>1, e.g. max 255, min 0 -> 127.

Decomposition:
- Package spo2_pkg: FRAC/QW defaults, FSM state enum {IDLE, MULT, DIV, DONE}, numerator/denominator width constants (24/16).
- One sub-module, seq_divider: start/busy/done handshake, 24-bit dividend, 16-bit divisor, QW-bit quotient, one bit per cycle.
- The zero and saturation checks stay in the parent.

Test Plan:
- Normal ratio of 1.0 (WINDOW=16): IR ramps 100..200, RED ramps 50..100 over 16 valid strobes.
  - Expect IR_AC=100, IR_DC=150, RED_AC=50, RED_DC=75.
  - Ratio=0x100, Ratio_Valid 14 cycles after close, Err=Sat=0.
- Non-integer ratio: IR spans 100..150, RED spans 100..200.
  - Expect IR_AC=50, IR_DC=125, RED_AC=100, RED_DC=150.
  - Ratio=0x1AA (12500*256/7500 = 426, truncated).
- Saturation: IR spans 100..101, RED spans 0..255.
  - Expect IR_AC=1, IR_DC=100, RED_DC=127.
  - Ratio=0xFFF, Ratio_Sat=1, Ratio_Valid at E+2.
- Zero divisor: constant IR=80, any RED.
  - Expect IR_AC=0, Ratio=0, Ratio_Err=1.
- Back-to-back windows with Sample_Valid every cycle and WINDOW=16: two consecutive Ratio_Valid pulses 16 cycles apart, Overrun=0.
- Reset: assert rst_n=0 mid-DIV.
  - Expect all outputs 0 immediately and no Ratio_Valid pulse.
  - After release, a fresh 16-sample window yields a correct result.
